// File: rtl/contador_arbitro_if.sv
// contador_arbitro_if: requester-side bundle of the counter arbiter.
// master = requesters (drive jobs), slave = contador_arbitro (returns grant/results).
interface contador_arbitro_if #(
  parameter int ANCHO   = 16,
  parameter int N_ANCHO = 16
) ();
  logic [1:0]         req;
  logic [1:0]         modo0;
  logic [1:0]         modo1;
  logic [ANCHO-1:0]   d0;
  logic [ANCHO-1:0]   d1;
  logic [N_ANCHO-1:0] n0;
  logic [N_ANCHO-1:0] n1;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic [1:0]         err;
  logic [ANCHO-1:0]   resultado;
  logic               wrap;

  modport master (
    output req, modo0, modo1, d0, d1, n0, n1,
    input  gnt, done, err, resultado, wrap
  );

  modport slave (
    input  req, modo0, modo1, d0, d1, n0, n1,
    output gnt, done, err, resultado, wrap
  );
endinterface

// File: rtl/contador_arbitro.sv
// contador_arbitro: shares one external 16-bit counter between two requesters.
// Each job loads a start value, counts n cycles in the requested mode and
// returns the final Q plus a wrap flag (RCO[3] seen while counting).
// Optional macro CONTADOR_PRIO_FIJA_EN: fixed priority (requester 0 wins ties)
// instead of round-robin.
//
// state | meaning
// IDLE  | counter released, sampling req
// LOAD  | parallel-load latched start value into the counter
// COUNT | counter running for n cycles in the latched mode
// DONE  | capture Q and wrap, pulse done for the winner
// ERR   | latched mode was a load (11), pulse err for the winner
module contador_arbitro #(
  parameter int ANCHO   = 16,
  parameter int N_ANCHO = 16
) (
  input  logic             clk,
  input  logic             reset,
  contador_arbitro_if.slave bus,
  output logic             enb,
  output logic [1:0]       modo,
  output logic [ANCHO-1:0] D,
  input  logic [ANCHO-1:0] Q,
  input  logic [3:0]       RCO
);

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, DONE, ERR} estado_t;

  estado_t            estado, estado_sig;
  logic               w, w_sig;
  logic [1:0]         modo_sel;
  logic [1:0]         modo_l;
  logic [ANCHO-1:0]   d_l;
  logic [N_ANCHO-1:0] n_l, resto;
  logic               wrap_l;

  // Only the top ripple-carry bit matters to the controller.
  logic unused_rco;
  assign unused_rco = ^RCO[2:0];

`ifdef CONTADOR_PRIO_FIJA_EN
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  always_comb begin
    w_sig = ~bus.req[0];
  end
`else
  logic ptr;

  // Round-robin: on a tie, the requester not served last wins.
  always_comb begin
    w_sig = 1'b0;
    if (bus.req == 2'b11) w_sig = ptr;
    else                  w_sig = bus.req[1];
  end

  // Pointer moves to the other requester after every finished or rejected job.
  always_ff @(posedge clk) begin
    if (reset)                                ptr <= 1'b0;
    else if (estado == DONE || estado == ERR) ptr <= ~w;
  end
`endif

  // Mode of the requester that would win this cycle.
  always_comb begin
    modo_sel = w_sig ? bus.modo1 : bus.modo0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  // Next state and counter-side outputs decoded from state.
  always_comb begin
    estado_sig = estado;
    enb        = 1'b0;
    modo       = 2'b00;
    D          = '0;
    case (estado)
      IDLE: begin
        if (|bus.req) estado_sig = (modo_sel == 2'b11) ? ERR : LOAD;
      end
      LOAD: begin
        enb        = 1'b1;
        modo       = 2'b11;
        D          = d_l;
        estado_sig = (n_l == '0) ? DONE : COUNT;
      end
      COUNT: begin
        enb  = 1'b1;
        modo = modo_l;
        if (resto == N_ANCHO'(1)) estado_sig = DONE;
      end
      DONE: begin
        // Mode held so RCO keeps describing the latched count direction.
        modo       = modo_l;
        estado_sig = IDLE;
      end
      ERR:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // Job latching, cycle counting, wrap tracking and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.gnt       <= 2'b00;
      bus.done      <= 2'b00;
      bus.err       <= 2'b00;
      bus.resultado <= '0;
      bus.wrap      <= 1'b0;
      w             <= 1'b0;
      modo_l        <= 2'b00;
      d_l           <= '0;
      n_l           <= '0;
      resto         <= '0;
      wrap_l        <= 1'b0;
    end else begin
      bus.done <= 2'b00;
      bus.err  <= 2'b00;
      case (estado)
        IDLE: begin
          if (|bus.req) begin
            w       <= w_sig;
            modo_l  <= modo_sel;
            d_l     <= w_sig ? bus.d1 : bus.d0;
            n_l     <= w_sig ? bus.n1 : bus.n0;
            bus.gnt <= w_sig ? 2'b10 : 2'b01;
            wrap_l  <= 1'b0;
          end
        end
        LOAD: resto <= n_l;
        COUNT: begin
          resto <= resto - N_ANCHO'(1);
          if (RCO[3]) wrap_l <= 1'b1;
        end
        DONE: begin
          bus.resultado <= Q;
          bus.wrap      <= wrap_l | RCO[3];
          bus.done      <= w ? 2'b10 : 2'b01;
          bus.gnt       <= 2'b00;
        end
        ERR: begin
          bus.err <= w ? 2'b10 : 2'b01;
          bus.gnt <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_contador_arbitro.sv
// Bench for contador_arbitro: behavioural counter model on the counter side,
// job table, randomized jobs against an arithmetic reference, and hand-written
// round-robin and mid-job reset sequences.
module tb_contador_arbitro;
  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] D;
  logic [15:0] q_cnt = '0;
  logic [3:0]  rco;

  int checks = 0;
  int errors = 0;

  contador_arbitro_if #(.ANCHO(16), .N_ANCHO(16)) bus ();

  contador_arbitro #(.ANCHO(16), .N_ANCHO(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .enb   (enb),
    .modo  (modo),
    .D     (D),
    .Q     (q_cnt),
    .RCO   (rco)
  );

  always #5 clk = ~clk;

  // RCO[3]: the next step in this mode would wrap around.
  function automatic bit term(input logic [1:0] m, input logic [15:0] q);
    case (m)
      2'b00:   return q == 16'hFFFF;
      2'b01:   return q == 16'h0000;
      2'b10:   return q < 16'd3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] step(input logic [1:0] m, input logic [15:0] q);
    case (m)
      2'b00:   return q + 16'd1;
      2'b01:   return q - 16'd1;
      2'b10:   return q - 16'd3;
      default: return q;
    endcase
  endfunction

  // External counter.
  always @(posedge clk) begin
    if (enb) q_cnt <= (modo == 2'b11) ? D : step(modo, q_cnt);
  end
  assign rco = {term(modo, q_cnt), 3'b000};

  // Reference: counter sees d, d+s, ..., d+n*s at the COUNT/DONE edges.
  task automatic ref_job(input logic [1:0] m, input logic [15:0] d, input int n,
                         output logic [15:0] r, output bit wr);
    logic [15:0] q;
    q  = d;
    wr = 1'b0;
    for (int j = 0; j <= n; j++) begin
      if (term(m, q)) wr = 1'b1;
      if (j < n) q = step(m, q);
    end
    r = q;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant must never be both high.
  always @(negedge clk) begin
    if (bus.gnt == 2'b11) begin
      checks++;
      errors++;
      $display("FAIL gnt_onehot: got %b expected one-hot or zero", bus.gnt);
    end
  end

  task automatic run_job(input bit w, input logic [1:0] m, input logic [15:0] d, input int n,
                         input logic [15:0] exp_r, input bit exp_w, input bit exp_e,
                         input string name);
    int  edges;
    bit  got;
    bit  saw_enb;
    logic [1:0] oh;
    oh = w ? 2'b10 : 2'b01;
    @(negedge clk);
    if (w) begin bus.modo1 = m; bus.d1 = d; bus.n1 = 16'(n); end
    else   begin bus.modo0 = m; bus.d0 = d; bus.n0 = 16'(n); end
    bus.req = oh;
    edges = 0; got = 1'b0; saw_enb = 1'b0;
    while (!got && edges < n + 20) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        chk({name, "_gnt"}, 32'(bus.gnt), 32'(oh));
        bus.req = 2'b00;
      end
      if (enb) saw_enb = 1'b1;
      if (bus.done != 2'b00 || bus.err != 2'b00) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done/err after %0d cycles", name, edges);
      return;
    end
    if (exp_e) begin
      chk({name, "_err"}, 32'(bus.err), 32'(oh));
      chk({name, "_done"}, 32'(bus.done), 0);
      chk({name, "_enb"}, 32'(saw_enb), 0);
      chk({name, "_lat"}, edges, 2);
    end else begin
      chk({name, "_done"}, 32'(bus.done), 32'(oh));
      chk({name, "_err"}, 32'(bus.err), 0);
      chk({name, "_lat"}, edges, n + 3);
    end
    chk({name, "_res"}, 32'(bus.resultado), 32'(exp_r));
    chk({name, "_wrap"}, 32'(bus.wrap), 32'(exp_w));
    chk({name, "_gnt_rel"}, 32'(bus.gnt), 0);
    @(negedge clk);
    chk({name, "_pulse"}, 32'({bus.done, bus.err}), 0);
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  m;
    logic [15:0] d;
    int          n;
    logic [15:0] r;
    bit          wr;
    bit          e;
  } vec_t;

  vec_t tabla[6];

  initial begin
    logic [15:0] last_r, er, d0r;
    bit          last_w, ew, wr_r;
    logic [1:0]  mr;
    int          nr, ndone;
    logic [1:0]  seq[4];

    tabla[0] = '{0, 2'b00, 16'h0010, 5, 16'h0015, 0, 0};
    tabla[1] = '{1, 2'b00, 16'hFFFE, 3, 16'h0001, 1, 0};
    tabla[2] = '{0, 2'b10, 16'h0009, 3, 16'h0000, 1, 0};
    tabla[3] = '{0, 2'b00, 16'h1234, 0, 16'h1234, 0, 0};
    tabla[4] = '{1, 2'b11, 16'hABCD, 4, 16'h1234, 0, 1};
    tabla[5] = '{1, 2'b01, 16'h0002, 4, 16'hFFFE, 1, 0};

    bus.req = 2'b00; bus.modo0 = 2'b00; bus.modo1 = 2'b00;
    bus.d0 = '0; bus.d1 = '0; bus.n0 = '0; bus.n1 = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_res", 32'(bus.resultado), 0);
    chk("rst_enb", 32'(enb), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_job(tabla[i].w, tabla[i].m, tabla[i].d, tabla[i].n,
              tabla[i].r, tabla[i].wr, tabla[i].e, $sformatf("tab%0d", i));

    last_r = 16'hFFFE;
    last_w = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wr_r = 1'($urandom_range(0, 1));
      mr   = 2'($urandom_range(0, 3));
      d0r  = 16'($urandom);
      nr   = $urandom_range(0, 12);
      if (mr == 2'b11) begin
        er = last_r; ew = last_w;
      end else begin
        ref_job(mr, d0r, nr, er, ew);
        last_r = er; last_w = ew;
      end
      run_job(wr_r, mr, d0r, nr, er, ew, mr == 2'b11, $sformatf("rnd%0d", i));
    end

    // Both requesters held: grants alternate starting at 0 after reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.modo0 = 2'b00; bus.d0 = 16'h0100; bus.n0 = 16'd2;
    bus.modo1 = 2'b00; bus.d1 = 16'h0200; bus.n1 = 16'd2;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    bus.req = 2'b11;
    ndone = 0;
    for (int c = 0; c < 100 && ndone < 4; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        if (ndone == 3) bus.req = 2'b00;
        chk($sformatf("rr_done%0d", ndone), 32'(bus.done), 32'(seq[ndone]));
        chk($sformatf("rr_res%0d", ndone), 32'(bus.resultado),
            (seq[ndone] == 2'b01) ? 32'h0102 : 32'h0202);
        @(negedge clk);
        chk($sformatf("rr_pulse%0d", ndone), 32'(bus.done), 0);
        ndone++;
      end
    end
    bus.req = 2'b00;
    chk("rr_count", ndone, 4);

    // Requester 0 served last, so a tie would favour 1 unless reset restores 0.
    run_job(0, 2'b00, 16'h0050, 2, 16'h0052, 0, 0, "pre_rst");

    @(negedge clk);
    bus.modo0 = 2'b00; bus.d0 = 16'h0300; bus.n0 = 16'd10;
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    chk("mid_enb_running", 32'(enb), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_gnt", 32'(bus.gnt), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_err", 32'(bus.err), 0);
    chk("mrst_res", 32'(bus.resultado), 0);
    chk("mrst_wrap", 32'(bus.wrap), 0);
    chk("mrst_enb", 32'(enb), 0);
    chk("mrst_modo", 32'(modo), 0);
    chk("mrst_D", 32'(D), 0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00 || bus.gnt != 2'b00) ndone++;
    end
    chk("mrst_quiet", ndone, 0);
    bus.req = 2'b11;
    @(negedge clk);
    chk("mrst_winner", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    ndone = 0;
    for (int c = 0; c < 40 && ndone == 0; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        ndone = 1;
        chk("post_done", 32'(bus.done), 32'h1);
        chk("post_res", 32'(bus.resultado), 32'h030A);
      end
    end
    chk("post_seen", ndone, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_arbitro.md
Name: contador_arbitro

Overview:
- Sequencer and arbiter that shares one 16-bit counter (clk, enb, D[15:0], modo[1:0] -> Q[15:0], RCO[3:0]) between two requesters.
- Each requester submits one job: a start value, a count mode and a cycle count.
- The controller loads the counter, runs it for the requested cycles, returns the final Q plus a wrap flag, then releases the counter.
- Sits between the requesters and the counter instance; it is the only driver of the counter's enb/modo/D.

Parameters:
- ANCHO, 16, counter data width (D, Q, resultado).
- N_ANCHO, 16, width of cycle-count fields n0/n1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  req[i] = requester i has a job pending; level, sampled only in IDLE.
- modo0, modo1  input  2 each  count mode of requester 0/1.
- d0, d1  input  ANCHO each  start value of requester 0/1.
- n0, n1  input  N_ANCHO each  number of count cycles for requester 0/1.
- gnt  output  2  one-hot; requester owning the counter.
- done  output  2  one-cycle pulse; job of requester i finished.
- err  output  2  one-cycle pulse; job of requester i rejected.
- resultado  output  ANCHO  final counter value of the last finished job.
- wrap  output  1  last finished job saw RCO[3]; valid with done.
- enb  output  1  counter enable.
- modo  output  2  counter mode.
- D  output  ANCHO  counter parallel-load data.
- Q  input  ANCHO  counter value.
- RCO  input  4  counter ripple-carry outputs; only RCO[3] is used.

Behaviour:
- Counter modo encoding: 00 up by 1, 01 down by 1, 10 down by 3, 11 parallel load of D. Counter updates on the rising edge while enb=1.
- Reset is synchronous and active-high. While reset=1 at a clock edge:
  - state goes to IDLE;
  - gnt, done, err, enb, modo, D, resultado and wrap all go to 0;
  - the round-robin pointer favours requester 0.
  - Reset mid-job aborts the job; no done or err is produced.
- States: IDLE, LOAD, COUNT, DONE, ERR. All outputs are registered or decoded from state; none is combinational from the inputs.
- IDLE:
  - Outputs: enb=0, modo=00, D=0, gnt=0.
  - On an edge with any req high, pick the winner w, latch modo_w, d_w and n_w, and set gnt[w].
  - Next state is ERR if the latched modo is 11; otherwise LOAD.
- Arbitration: round-robin. With a single req, that requester wins. With both high, the requester not served last wins. The pointer advances after every DONE or ERR.
- LOAD (1 cycle):
  - Outputs: enb=1, modo=11, D=latched d; the counter loads on the edge ending LOAD.
  - Next state is DONE if n=0; otherwise COUNT.
- COUNT (exactly n cycles):
  - Outputs: enb=1, modo=latched mode, D=0.
  - An internal remaining-cycles counter decrements every cycle; exit to DONE after the n-th cycle.
  - The wrap latch is set if RCO[3]=1 at any edge while in COUNT or DONE.
- DONE (1 cycle):
  - Outputs: enb=0; gnt still held.
  - On the edge ending DONE: resultado<=Q, wrap<=latch, done[w]<=1 for one cycle, gnt<=0, next state IDLE.
- ERR (1 cycle): enb=0; on the exit edge err[w]<=1 for one cycle, gnt<=0, next state IDLE; resultado and wrap are unchanged.
- Latency: req sampled at edge 0 -> LOAD after edge 0 -> COUNT after edges 1..n -> DONE after edge n+1 -> done/resultado visible after edge n+2.
- req and input changes after the latching edge are ignored until IDLE. A requester still holding req at IDLE is treated as a new job.
- The counter wraps naturally modulo 2^ANCHO; the controller does not saturate.
- n = 2^N_ANCHO-1 is legal (long job); no timeout.

Optional Feature:
- CONTADOR_PRIO_FIJA_EN: when defined, arbitration is fixed priority: requester 0 always wins simultaneous requests and the pointer logic is removed. When undefined, round-robin as above.

Test Plan:
- req0=1, d0=0x0010, modo0=00, n0=5 -> LOAD then 5 COUNT cycles; done[0] after edge 7; resultado=0x0015, wrap=0.
- req1=1, d1=0xFFFE, modo1=00, n1=3 -> resultado=0x0001, wrap=1, done[1] pulse only.
- req0=1, d0=0x0009, modo0=10, n0=3 -> resultado=0x0000; then n0=0, d0=0x1234 -> resultado=0x1234 two edges after LOAD.
- req0=req1=1 held, jobs n=2, default build -> grants alternate 0,1,0,1; each done pulse is one cycle and gnt is never both high.
- req1=1, modo1=11 -> err[1] pulse, enb never asserted, resultado unchanged.
- Assert reset during COUNT of a 10-cycle job -> next cycle all outputs 0, state IDLE, no done; a new req0 then wins.
